pad_input_conditioner: RTL and testbench
========================================

PAD_INPUT_CONDITIONER -- requirements
Module: pad_input_conditioner

Interface
REQ-001 SHALL have parameter NPADS, default 4, number of conditioned pad inputs.
REQ-002 SHALL have parameter CNT_W, default 8, debounce counter width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (minimum 2).
REQ-004 SHALL have port clk_i  input  1  single clock.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pad_i  input  NPADS  raw asynchronous values from the input pad cells' pad_out_o.
REQ-007 SHALL have port prescale_i  input  16  tick divider; tick every prescale_i+1 cycles.
REQ-008 SHALL have port threshold_i  input  CNT_W  ticks a new level must persist before acceptance.
REQ-009 SHALL have port edge_sel_i  input  2  interrupt edge: 00 none, 01 rise, 10 fall, 11 both.
REQ-010 SHALL have port irq_clr_i  input  NPADS  per-pad sticky interrupt clear.
REQ-011 SHALL have port pad_o  output  NPADS  conditioned level.
REQ-012 SHALL have port rise_o  output  NPADS  one-cycle pulse on accepted 0->1.
REQ-013 SHALL have port fall_o  output  NPADS  one-cycle pulse on accepted 1->0.
REQ-014 SHALL have port irq_o  output  NPADS  sticky per-pad interrupt.

Function
REQ-015 Each pad_i bit SHALL pass through SYNC_STAGES flops; the last stage is "sync".
REQ-016 Prescaler SHALL count 0..prescale_i, assert tick on the cycle it equals prescale_i, then wrap to 0; prescale_i=0 yields tick every cycle.
REQ-017 Per pad FSM SHALL have states STABLE and COUNTING; STABLE -> COUNTING with cnt=0 when sync != pad_o.
REQ-018 In COUNTING, sync == pad_o SHALL return to STABLE with cnt=0 and no pulse (glitch rejected).
REQ-019 In COUNTING on tick, if cnt >= threshold_i, pad_o SHALL take sync, the matching rise_o/fall_o SHALL pulse for exactly one cycle, state -> STABLE; else cnt increments.
REQ-020 Comparison SHALL use live threshold_i; lowering it mid-count accepts on the next tick; cnt SHALL never wrap.
REQ-021 With prescale_i=0 and threshold_i=T, a clean pad_i step SHALL appear on pad_o SYNC_STAGES+T+2 rising edges after the first edge sampling it.
REQ-022 irq_o[i] SHALL set on a pulse selected by edge_sel_i and clear on irq_clr_i[i]; simultaneous set and clear SHALL leave it set.
REQ-023 Pads SHALL operate independently; simultaneous accepts on several pads SHALL all pulse in the same cycle.

Reset
REQ-024 rst_i SHALL asynchronously clear synchronizers, prescaler, cnt, pad_o, rise_o, fall_o, irq_o to 0 and FSMs to STABLE.
REQ-025 Reset asserted mid-count SHALL discard the pending change; after release a pad held at 1 SHALL be reacquired via the full REQ-021 latency.

Configuration
REQ-026 With macro PAD_INPUT_DEBOUNCE_EN defined, debounce (REQ-016..REQ-021) SHALL be compiled in.
REQ-027 Without PAD_INPUT_DEBOUNCE_EN, prescaler, counters and FSM SHALL be absent; pad_o SHALL register sync (latency SYNC_STAGES+1); pulses and irq SHALL derive from that register; prescale_i and threshold_i SHALL be ignored.

Structure
REQ-028 Package pad_input_cond_pkg SHALL hold the FSM state enum and edge_sel enum (EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-029 Per-pad sync+FSM+counter SHALL be sub-module pad_input_debounce, instantiated NPADS times; prescaler and irq logic remain in the top.

Verification
REQ-030 prescale_i=0, threshold_i=3, pad_i[0] 0->1 held -> pad_o[0] rises 7 edges later, rise_o[0] single pulse, fall_o quiet.
REQ-031 threshold_i=3, 2-cycle pulse on pad_i[1] -> pad_o[1], rise_o, fall_o, irq_o stay 0.
REQ-032 prescale_i=4, threshold_i=2, held step -> acceptance on the 3rd tick (ticks every 5 cycles), pad_o lags accordingly.
REQ-033 edge_sel_i=10, pad 2 toggles 0->1->0 -> irq_o[2] sets only after the fall; irq_clr_i[2] same cycle as new fall -> irq_o[2] stays 1.
REQ-034 rst_i asserted while pad 3 COUNTING -> all outputs 0 immediately; release with pad_i[3]=1 -> reacquired after 7 edges (T=3).
REQ-035 Build without PAD_INPUT_DEBOUNCE_EN, 1-cycle pad_i pulse -> pad_o follows after 3 edges, rise_o and fall_o each pulse once.

Source files
------------

// File: rtl/pad_input_cond_pkg.sv
// Shared types for the pad input conditioner: debounce FSM states and interrupt edge selection.
// Used by pad_input_debounce and pad_input_conditioner in both builds (PAD_INPUT_DEBOUNCE_EN on or off).
package pad_input_cond_pkg;

   localparam int unsigned PRESC_W    = 16;
   localparam int unsigned EDGE_SEL_W = 2;

   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_e;

   typedef enum logic [EDGE_SEL_W-1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_e;

   function automatic logic edge_sel_rise(input edge_sel_e sel);
      return (sel == EDGE_RISE) || (sel == EDGE_BOTH);
   endfunction

   function automatic logic edge_sel_fall(input edge_sel_e sel);
      return (sel == EDGE_FALL) || (sel == EDGE_BOTH);
   endfunction

endpackage

// File: rtl/pad_input_debounce.sv
// One pad: SYNC_STAGES-deep synchronizer, then a tick-paced debounce FSM, or a plain
// registered follower of the synchronizer when PAD_INPUT_DEBOUNCE_EN is not defined.
module pad_input_debounce
   import pad_input_cond_pkg::*;
#(
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pad_i,
   input  logic             tick_i,
   input  logic [CNT_W-1:0] threshold_i,
   output logic             pad_o,
   output logic             rise_o,
   output logic             fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_c;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Metastability synchronizer; the last stage is the only one the logic may look at.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      end
   end

   assign sync_c = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

`ifdef PAD_INPUT_DEBOUNCE_EN

   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= DB_STABLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A new level must survive threshold_i+1 ticks; any return to the old level aborts it.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         DB_STABLE: begin
            if (sync_c != level_q) begin
               state_d = DB_COUNTING;
               cnt_d   = '0;
            end
         end
         DB_COUNTING: begin
            if (sync_c == level_q) begin
               state_d = DB_STABLE;
               cnt_d   = '0;
            end else if (tick_i) begin
               if (cnt_q >= threshold_i) begin
                  level_d = sync_c;
                  rise_d  = sync_c;
                  fall_d  = ~sync_c;
                  state_d = DB_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = DB_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

`else

   logic unused_c;
   assign unused_c = ^{tick_i, threshold_i};

   always_comb begin
      level_d = sync_c;
      rise_d  = sync_c & ~level_q;
      fall_d  = ~sync_c & level_q;
   end

`endif

   assign pad_o  = level_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Conditions NPADS asynchronous pad inputs: synchronize, optionally debounce (PAD_INPUT_DEBOUNCE_EN),
// flag accepted edges and keep a sticky, individually clearable interrupt per pad.
module pad_input_conditioner
   import pad_input_cond_pkg::*;
#(
   parameter int unsigned NPADS       = 4,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NPADS-1:0]      pad_i,
   input  logic [PRESC_W-1:0]    prescale_i,
   input  logic [CNT_W-1:0]      threshold_i,
   input  logic [EDGE_SEL_W-1:0] edge_sel_i,
   input  logic [NPADS-1:0]      irq_clr_i,
   output logic [NPADS-1:0]      pad_o,
   output logic [NPADS-1:0]      rise_o,
   output logic [NPADS-1:0]      fall_o,
   output logic [NPADS-1:0]      irq_o
);

   logic             tick_c;
   logic [NPADS-1:0] irq_q, irq_d;
   edge_sel_e        edge_sel_c;
   logic             sel_rise_c;
   logic             sel_fall_c;

`ifdef PAD_INPUT_DEBOUNCE_EN

   logic [PRESC_W-1:0] presc_q, presc_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Wrap on >= so a prescale_i lowered below the running count cannot strand the counter.
   always_comb begin
      tick_c  = (presc_q >= prescale_i);
      presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
   end

`else

   logic unused_c;
   assign unused_c = ^prescale_i;
   assign tick_c   = 1'b0;

`endif

   for (genvar g = 0; g < NPADS; g++) begin : g_pad
      pad_input_debounce #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_debounce (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .pad_i       (pad_i[g]),
         .tick_i      (tick_c),
         .threshold_i (threshold_i),
         .pad_o       (pad_o[g]),
         .rise_o      (rise_o[g]),
         .fall_o      (fall_o[g])
      );
   end

   assign edge_sel_c = edge_sel_e'(edge_sel_i);
   assign sel_rise_c = edge_sel_rise(edge_sel_c);
   assign sel_fall_c = edge_sel_fall(edge_sel_c);

   // Set has priority over clear so an edge arriving with the clear is never lost.
   always_comb begin
      irq_d = (irq_q & ~irq_clr_i)
            | ({NPADS{sel_rise_c}} & rise_o)
            | ({NPADS{sel_fall_c}} & fall_o);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= '0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed bench for pad_input_conditioner; pulse events go through an expectation queue,
// levels and interrupts are checked inline. Covers the debounce build when PAD_INPUT_DEBOUNCE_EN is defined.
module tb_pad_input_conditioner;
   import pad_input_cond_pkg::*;

   localparam int unsigned NPADS       = 4;
   localparam int unsigned CNT_W       = 8;
   localparam int unsigned SYNC_STAGES = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic [NPADS-1:0]      pad_i = '0;
   logic [PRESC_W-1:0]    prescale_i = '0;
   logic [CNT_W-1:0]      threshold_i = CNT_W'(3);
   logic [EDGE_SEL_W-1:0] edge_sel_i = EDGE_NONE;
   logic [NPADS-1:0]      irq_clr_i = '0;
   logic [NPADS-1:0]      pad_o;
   logic [NPADS-1:0]      rise_o;
   logic [NPADS-1:0]      fall_o;
   logic [NPADS-1:0]      irq_o;

   typedef struct {
      int cyc;
      int pad;
      bit rise;
   } ev_t;

   ev_t exp_q[$];
   int  cyc      = 0;
   int  rel0     = 0;
   int  n_assert = 0;
   int  n_fail   = 0;

   pad_input_conditioner #(
      .NPADS       (NPADS),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pad_i       (pad_i),
      .prescale_i  (prescale_i),
      .threshold_i (threshold_i),
      .edge_sel_i  (edge_sel_i),
      .irq_clr_i   (irq_clr_i),
      .pad_o       (pad_o),
      .rise_o      (rise_o),
      .fall_o      (fall_o),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ev_word(input int c, input int p, input bit r);
      return 32'(c * 16 + p * 2 + int'(r));
   endfunction

   task automatic expect_ev(input int c, input int p, input bit r);
      exp_q.push_back('{cyc: c, pad: p, rise: r});
   endtask

   task automatic got_ev(input int p, input bit r);
      ev_t e;
      if (exp_q.size() == 0) begin
         check("unexpected_pulse", ev_word(cyc, p, r), 32'hffff_ffff);
      end else begin
         e = exp_q.pop_front();
         check("pulse_event", ev_word(cyc, p, r), ev_word(e.cyc, e.pad, e.rise));
      end
   endtask

   // Pulse monitor: sampled 1 time unit after each rising edge.
   always @(posedge clk_i) begin
      cyc = cyc + 1;
      #1;
      if (!rst_i) begin
         for (int i = 0; i < int'(NPADS); i++) begin
            if (rise_o[i]) got_ev(i, 1'b1);
            if (fall_o[i]) got_ev(i, 1'b0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk_i);
   endtask

   // Called at a negedge; checks asynchronous clearing, then releases on a later negedge.
   task automatic do_reset(input string tag);
      rst_i = 1'b1;
      #1;
      check({tag, "_pad_o"},  32'(pad_o),  32'h0);
      check({tag, "_rise_o"}, 32'(rise_o), 32'h0);
      check({tag, "_fall_o"}, 32'(fall_o), 32'h0);
      check({tag, "_irq_o"},  32'(irq_o),  32'h0);
      step(2);
      rst_i = 1'b0;
      rel0  = cyc;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s;
      int acc;
      int ticks;

      step(1);
      do_reset("reset");
      step(2);

`ifdef PAD_INPUT_DEBOUNCE_EN
      // Clean step on pad 0, prescale 0, threshold 3: accepted on the 7th edge.
      prescale_i  = '0;
      threshold_i = CNT_W'(3);
      edge_sel_i  = EDGE_BOTH;
      pad_i[0] = 1'b1;
      s = cyc + 1;
      expect_ev(s + 6, 0, 1'b1);
      wait_until(s + 5);
      check("db_latency_early", 32'(pad_o), 32'h0);
      step(1);
      check("db_accept_level", 32'(pad_o), 32'h1);
      check("db_accept_rise", 32'(rise_o), 32'h1);
      step(1);
      check("db_rise_one_cycle", 32'(rise_o), 32'h0);
      check("db_irq_both", 32'(irq_o), 32'h1);
      irq_clr_i = 4'b0001;
      step(1);
      irq_clr_i = '0;
      check("db_irq_clear", 32'(irq_o), 32'h0);

      // Two-cycle glitch on pad 1 is rejected.
      pad_i[1] = 1'b1;
      step(2);
      pad_i[1] = 1'b0;
      step(12);
      check("db_glitch_level", 32'(pad_o), 32'h1);
      check("db_glitch_irq", 32'(irq_o), 32'h0);

      // Fall-only interrupt on pad 2; clear coincident with the fall pulse loses to the set.
      edge_sel_i = EDGE_FALL;
      pad_i[2] = 1'b1;
      s = cyc + 1;
      expect_ev(s + 6, 2, 1'b1);
      wait_until(s + 8);
      check("db_rise_level_p2", 32'(pad_o), 32'h5);
      check("db_rise_no_irq", 32'(irq_o), 32'h0);
      pad_i[2] = 1'b0;
      s = cyc + 1;
      expect_ev(s + 6, 2, 1'b0);
      wait_until(s + 6);
      check("db_fall_pulse", 32'(fall_o), 32'h4);
      irq_clr_i = 4'b0100;
      step(1);
      irq_clr_i = '0;
      check("db_set_beats_clr", 32'(irq_o), 32'h4);
      irq_clr_i = 4'b0100;
      step(1);
      irq_clr_i = '0;
      check("db_irq2_clear", 32'(irq_o), 32'h0);

      // Prescale 4, threshold 2: acceptance on the third tick after counting starts.
      prescale_i  = PRESC_W'(4);
      threshold_i = CNT_W'(2);
      edge_sel_i  = EDGE_BOTH;
      pad_i       = '0;
      do_reset("presc_reset");
      step(3);
      pad_i[1] = 1'b1;
      s = cyc + 1;
      ticks = 0;
      acc   = s + 2;
      while (ticks < 3) begin
         acc++;
         if ((acc - rel0) % 5 == 0) ticks++;
      end
      expect_ev(acc, 1, 1'b1);
      wait_until(acc - 1);
      check("presc_before_accept", 32'(pad_o), 32'h0);
      step(1);
      check("presc_accept", 32'(pad_o), 32'h2);

      // Reset while pad 3 is counting; pads 1 and 3 reacquire together afterwards.
      prescale_i  = '0;
      threshold_i = CNT_W'(3);
      step(2);
      pad_i[3] = 1'b1;
      step(4);
      check("midcount_pad_o", 32'(pad_o), 32'h2);
      do_reset("midcount_reset");
      s = cyc + 1;
      expect_ev(s + 6, 1, 1'b1);
      expect_ev(s + 6, 3, 1'b1);
      wait_until(s + 5);
      check("reacq_early", 32'(pad_o), 32'h0);
      step(1);
      check("reacq_level", 32'(pad_o), 32'ha);
      check("reacq_rise", 32'(rise_o), 32'ha);
`else
      // Single-cycle pulse on pad 0 follows after 3 edges, both pulses fire once.
      edge_sel_i = EDGE_BOTH;
      pad_i[0] = 1'b1;
      s = cyc + 1;
      expect_ev(s + 2, 0, 1'b1);
      expect_ev(s + 3, 0, 1'b0);
      step(1);
      pad_i[0] = 1'b0;
      step(1);
      check("nd_latency_early", 32'(pad_o), 32'h0);
      step(1);
      check("nd_follow_high", 32'(pad_o), 32'h1);
      step(1);
      check("nd_follow_low", 32'(pad_o), 32'h0);
      check("nd_irq_both", 32'(irq_o), 32'h1);
      step(1);
      irq_clr_i = 4'b0001;
      step(1);
      irq_clr_i = '0;
      check("nd_irq_clear", 32'(irq_o), 32'h0);

      // Fall-only interrupt on pad 2; clear coincident with the fall pulse loses to the set.
      edge_sel_i = EDGE_FALL;
      pad_i[2] = 1'b1;
      s = cyc + 1;
      expect_ev(s + 2, 2, 1'b1);
      wait_until(s + 4);
      check("nd_rise_no_irq", 32'(irq_o), 32'h0);
      pad_i[2] = 1'b0;
      s = cyc + 1;
      expect_ev(s + 2, 2, 1'b0);
      wait_until(s + 2);
      check("nd_fall_pulse", 32'(fall_o), 32'h4);
      irq_clr_i = 4'b0100;
      step(1);
      irq_clr_i = '0;
      check("nd_set_beats_clr", 32'(irq_o), 32'h4);
      irq_clr_i = 4'b0100;
      step(1);
      irq_clr_i = '0;
      check("nd_irq2_clear", 32'(irq_o), 32'h0);

      // Pads 1 and 3 rise together; rise-only then no-edge selection.
      edge_sel_i = EDGE_RISE;
      pad_i = 4'b1010;
      s = cyc + 1;
      expect_ev(s + 2, 1, 1'b1);
      expect_ev(s + 2, 3, 1'b1);
      wait_until(s + 2);
      check("nd_multi_level", 32'(pad_o), 32'ha);
      check("nd_multi_rise", 32'(rise_o), 32'ha);
      step(1);
      check("nd_irq_rise", 32'(irq_o), 32'ha);
      edge_sel_i = EDGE_NONE;
      pad_i = '0;
      s = cyc + 1;
      expect_ev(s + 2, 1, 1'b0);
      expect_ev(s + 2, 3, 1'b0);
      wait_until(s + 3);
      check("nd_none_level", 32'(pad_o), 32'h0);
      check("nd_irq_none", 32'(irq_o), 32'ha);

      // Asynchronous reset with pad 0 high; reacquired after the full latency.
      edge_sel_i = EDGE_BOTH;
      pad_i[0] = 1'b1;
      s = cyc + 1;
      expect_ev(s + 2, 0, 1'b1);
      wait_until(s + 3);
      check("nd_pre_reset_irq", 32'(irq_o), 32'hb);
      do_reset("nd_mid_reset");
      s = cyc + 1;
      expect_ev(s + 2, 0, 1'b1);
      wait_until(s + 1);
      check("nd_reacq_early", 32'(pad_o), 32'h0);
      step(1);
      check("nd_reacq_level", 32'(pad_o), 32'h1);
`endif

      step(10);
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
